// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN configuration path.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_e;

  // Largest byte entry among the first n entries of a packed byte table.
  function automatic int max_of(input logic [63:0] tbl, input int n);
    int m;
    m = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < n && int'(tbl[i*8 +: 8]) > m) m = int'(tbl[i*8 +: 8]);
    end
    return m;
  endfunction

endpackage

// File: rtl/cnn_load_counter.sv
// Nested addr/sel/layer counter walking the per-layer memory table in load order.
module cnn_load_counter
  import cnn_pkg::*;
#(
  parameter int                         N_LAYERS     = 3,
  parameter logic [N_LAYERS-1:0][7:0]   LAYER_N_MEMS = {8'd4, 8'd2, 8'd1},
  parameter logic [N_LAYERS-1:0][7:0]   LAYER_DEPTH  = {8'd3, 8'd4, 8'd7},
  parameter int                         LAYER_BITS   = 2,
  parameter int                         SEL_BITS     = 2,
  parameter int                         ADDR_BITS    = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  advance_i,
  output logic [LAYER_BITS-1:0] layer_o,
  output logic [SEL_BITS-1:0]   sel_o,
  output logic [ADDR_BITS-1:0]  addr_o,
  output logic                  last_o
);

  logic [LAYER_BITS-1:0] r_layer;
  logic [SEL_BITS-1:0]   r_sel;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [7:0]            w_depth;
  logic [7:0]            w_nMems;
  logic                  w_addrWrap;
  logic                  w_selWrap;
  logic                  w_lastLayer;

  // Only the current layer's geometry governs the wrap points.
  assign w_depth     = LAYER_DEPTH[r_layer];
  assign w_nMems     = LAYER_N_MEMS[r_layer];
  assign w_addrWrap  = (8'(r_addr) == (w_depth - 8'd1));
  assign w_selWrap   = (8'(r_sel) == (w_nMems - 8'd1));
  assign w_lastLayer = (int'(r_layer) == (N_LAYERS - 1));

  assign last_o  = w_lastLayer & w_selWrap & w_addrWrap;
  assign layer_o = r_layer;
  assign sel_o   = r_sel;
  assign addr_o  = r_addr;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_layer <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
    end else if (advance_i) begin
      if (w_addrWrap) begin
        r_addr <= '0;
        if (w_selWrap) begin
          r_sel   <= '0;
          r_layer <= r_layer + 1'b1;
        end else begin
          r_sel <= r_sel + 1'b1;
        end
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnn_weight_loader.sv
// Streams host words into every layer's weight/bias memory, then raises cfg_done_o.
module cnn_weight_loader
  import cnn_pkg::*;
#(
  parameter int                       WORD_SIZE        = 16,
  parameter int                       N_LAYERS         = 3,
  parameter logic [N_LAYERS-1:0][7:0] LAYER_N_MEMS     = {8'd4, 8'd2, 8'd1},
  parameter logic [N_LAYERS-1:0][7:0] LAYER_DEPTH      = {8'd3, 8'd4, 8'd7},
  parameter int                       RAM_SELECT_BITS  = $clog2(max_of(64'(LAYER_N_MEMS), N_LAYERS)),
  parameter int                       RAM_ADDRESS_BITS = $clog2(max_of(64'(LAYER_DEPTH), N_LAYERS))
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      load_i,
  input  logic                                      pipe_busy_i,
  input  logic                                      valid_i,
  output logic                                      ready_o,
  input  logic [WORD_SIZE-1:0]                      data_i,
  output logic [N_LAYERS-1:0]                       w_en_o,
  output logic [RAM_SELECT_BITS+RAM_ADDRESS_BITS-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0]                      mem_data_o,
  output logic                                      cfg_done_o,
  output logic                                      busy_o
);

  localparam int LAYER_BITS = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [N_LAYERS-1:0] LAYER_ONE = 1;

  loader_state_e                               r_state;
  logic                                        r_ready;
  logic                                        r_busy;
  logic                                        r_cfgDone;
  logic [N_LAYERS-1:0]                         r_wEn;
  logic [RAM_SELECT_BITS+RAM_ADDRESS_BITS-1:0] r_memAddr;
  logic [WORD_SIZE-1:0]                        r_memData;

  logic                        w_start;
  logic                        w_accept;
  logic                        w_last;
  logic [LAYER_BITS-1:0]       w_layer;
  logic [RAM_SELECT_BITS-1:0]  w_sel;
  logic [RAM_ADDRESS_BITS-1:0] w_addr;

  // A load request is only honoured when idle or done and the pipeline is quiet.
  assign w_start  = (r_state != LOAD) & load_i & ~pipe_busy_i;
  assign w_accept = (r_state == LOAD) & valid_i & r_ready;

  cnn_load_counter #(
    .N_LAYERS     (N_LAYERS),
    .LAYER_N_MEMS (LAYER_N_MEMS),
    .LAYER_DEPTH  (LAYER_DEPTH),
    .LAYER_BITS   (LAYER_BITS),
    .SEL_BITS     (RAM_SELECT_BITS),
    .ADDR_BITS    (RAM_ADDRESS_BITS)
  ) u_counter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (w_start),
    .advance_i (w_accept),
    .layer_o   (w_layer),
    .sel_o     (w_sel),
    .addr_o    (w_addr),
    .last_o    (w_last)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_cfgDone <= 1'b0;
      r_wEn     <= '0;
      r_memAddr <= '0;
      r_memData <= '0;
    end else begin
      r_wEn <= '0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= LOAD;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          // Address and data hold their last values whenever no word is accepted.
          if (w_accept) begin
            r_wEn     <= LAYER_ONE << w_layer;
            r_memAddr <= {w_sel, w_addr};
            r_memData <= data_i;
            if (w_last) begin
              r_state   <= DONE;
              r_ready   <= 1'b0;
              r_busy    <= 1'b0;
              r_cfgDone <= 1'b1;
            end
          end
        end
        DONE: begin
          if (w_start) begin
            r_state   <= LOAD;
            r_ready   <= 1'b1;
            r_busy    <= 1'b1;
            r_cfgDone <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o    = r_ready;
  assign busy_o     = r_busy;
  assign cfg_done_o = r_cfgDone;
  assign w_en_o     = r_wEn;
  assign mem_addr_o = r_memAddr;
  assign mem_data_o = r_memData;

endmodule

// File: tb/tb_cnn_weight_loader.sv
// Directed self-checking bench for cnn_weight_loader with the default 3-layer table.
module tb_cnn_weight_loader;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        load_i;
  logic        pipe_busy_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] data_i;
  logic [2:0]  w_en_o;
  logic [4:0]  mem_addr_o;
  logic [15:0] mem_data_o;
  logic        cfg_done_o;
  logic        busy_o;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] expWen  [27];
  logic [4:0] expAddr [27];

  cnn_weight_loader dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (load_i),
    .pipe_busy_i (pipe_busy_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .w_en_o      (w_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .cfg_done_o  (cfg_done_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  assert property (@(posedge clk_i) $onehot0(w_en_o));
  assert property (@(posedge clk_i) ready_o |-> busy_o);

  // Expected write order: layer 0 is 1 mem x 7 words, layer 1 is 2 x 4, layer 2 is 4 x 3.
  task automatic build_tables();
    int nMems [3];
    int depth [3];
    int idx;
    nMems = '{1, 2, 4};
    depth = '{7, 4, 3};
    idx = 0;
    for (int l = 0; l < 3; l++)
      for (int s = 0; s < nMems[l]; s++)
        for (int a = 0; a < depth[l]; a++) begin
          expWen[idx]  = 3'(1 << l);
          expAddr[idx] = {2'(s), 3'(a)};
          idx++;
        end
  endtask

  task automatic pulse_load();
    load_i = 1'b1;
    @(posedge clk_i); #1;
    load_i = 1'b0;
  endtask

  // Streams words 1..nWords from a LOAD state, checking each write one cycle after its accept.
  task automatic test_stream(input bit toggle, input int nWords, input string tag);
    int sent;
    bit acc;
    sent = 0;
    for (int cyc = 0; sent < nWords; cyc++) begin
      acc     = !toggle || (cyc % 2 == 0);
      valid_i = acc;
      data_i  = 16'(sent + 1);
      compared++;
      if (ready_o !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL %s ready[%0d]: got %b want 1", tag, sent, ready_o);
      end
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      if (acc) begin
        compared++;
        if (w_en_o !== expWen[sent]) begin
          mismatched++;
          $display("[TB] FAIL %s wen[%0d]: got %b want %b", tag, sent, w_en_o, expWen[sent]);
        end
        compared++;
        if (mem_addr_o !== expAddr[sent]) begin
          mismatched++;
          $display("[TB] FAIL %s addr[%0d]: got %h want %h", tag, sent, mem_addr_o, expAddr[sent]);
        end
        compared++;
        if (mem_data_o !== 16'(sent + 1)) begin
          mismatched++;
          $display("[TB] FAIL %s data[%0d]: got %h want %h", tag, sent, mem_data_o, 16'(sent + 1));
        end
        compared++;
        if (cfg_done_o !== (sent == 26)) begin
          mismatched++;
          $display("[TB] FAIL %s done[%0d]: got %b want %b", tag, sent, cfg_done_o, (sent == 26));
        end
        sent++;
      end else begin
        compared++;
        if (w_en_o !== 3'b000) begin
          mismatched++;
          $display("[TB] FAIL %s idle_wen[%0d]: got %b want 000", tag, sent, w_en_o);
        end
        if (sent > 0) begin
          compared++;
          if (mem_data_o !== 16'(sent)) begin
            mismatched++;
            $display("[TB] FAIL %s hold_data[%0d]: got %h want %h", tag, sent, mem_data_o, 16'(sent));
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; load_i = 1'b0; pipe_busy_i = 1'b0; valid_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    compared++;
    if ({ready_o, busy_o, cfg_done_o, w_en_o, mem_addr_o, mem_data_o} !== 27'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got rdy=%b busy=%b done=%b wen=%b addr=%h data=%h want all 0",
               ready_o, busy_o, cfg_done_o, w_en_o, mem_addr_o, mem_data_o);
    end
  endtask

  task automatic test_full_load();
    pulse_load();
    compared++;
    if (busy_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL full_busy: got %b want 1", busy_o);
    end
    test_stream(1'b0, 27, "full");
    @(posedge clk_i); #1;
    compared++;
    if ({w_en_o, cfg_done_o, ready_o, busy_o} !== 6'b000100) begin
      mismatched++;
      $display("[TB] FAIL full_after: got wen=%b done=%b rdy=%b busy=%b want 000 1 0 0",
               w_en_o, cfg_done_o, ready_o, busy_o);
    end
  endtask

  task automatic test_toggle_valid();
    pulse_load();
    compared++;
    if (cfg_done_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL toggle_done_clear: got %b want 0", cfg_done_o);
    end
    test_stream(1'b1, 27, "toggle");
  endtask

  task automatic test_done_ignores_words();
    valid_i = 1'b1;
    data_i  = 16'hFFFE;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      compared++;
      if ({ready_o, w_en_o, cfg_done_o, mem_data_o} !== {1'b0, 3'b000, 1'b1, 16'h001B}) begin
        mismatched++;
        $display("[TB] FAIL done_ignore[%0d]: got rdy=%b wen=%b done=%b data=%h want 0 000 1 001b",
                 c, ready_o, w_en_o, cfg_done_o, mem_data_o);
      end
    end
    load_i = 1'b1;
    @(posedge clk_i); #1;
    load_i  = 1'b0;
    valid_i = 1'b0;
    compared++;
    if ({cfg_done_o, ready_o, w_en_o} !== {1'b0, 1'b1, 3'b000}) begin
      mismatched++;
      $display("[TB] FAIL done_reload: got done=%b rdy=%b wen=%b want 0 1 000", cfg_done_o, ready_o, w_en_o);
    end
    test_stream(1'b0, 27, "reload");
  endtask

  task automatic test_pipe_busy();
    test_reset();
    load_i      = 1'b1;
    pipe_busy_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      compared++;
      if ({ready_o, busy_o} !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL pipe_busy_block[%0d]: got rdy=%b busy=%b want 0 0", c, ready_o, busy_o);
      end
    end
    pipe_busy_i = 1'b0;
    @(posedge clk_i); #1;
    load_i = 1'b0;
    compared++;
    if ({ready_o, busy_o} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL pipe_busy_release: got rdy=%b busy=%b want 1 1", ready_o, busy_o);
    end
  endtask

  task automatic test_reset_mid_load();
    test_stream(1'b0, 10, "partial");
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    compared++;
    if ({ready_o, busy_o, cfg_done_o, w_en_o, mem_addr_o, mem_data_o} !== 27'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: got rdy=%b busy=%b done=%b wen=%b addr=%h data=%h want all 0",
               ready_o, busy_o, cfg_done_o, w_en_o, mem_addr_o, mem_data_o);
    end
    pulse_load();
    valid_i = 1'b1;
    data_i  = 16'h0055;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    compared++;
    if ({w_en_o, mem_addr_o, mem_data_o} !== {3'b001, 5'd0, 16'h0055}) begin
      mismatched++;
      $display("[TB] FAIL midreset_first_write: got wen=%b addr=%h data=%h want 001 00 0055",
               w_en_o, mem_addr_o, mem_data_o);
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_full_load();
    test_toggle_valid();
    test_done_ignores_words();
    test_pipe_busy();
    test_reset_mid_load();
    repeat (2) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
